// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display controller.
package score_display_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;

  localparam logic [6:0] SEG_OFF_AL = 7'h7F;
  localparam logic [6:0] SEG_OFF_AH = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// BCD digit to seven-segment decoder, active-high segments, bit 6 = A ... bit 0 = G.
module bcd_to_seven_seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (bcd_i)
      4'd0: seg_o = 7'h7E;
      4'd1: seg_o = 7'h30;
      4'd2: seg_o = 7'h6D;
      4'd3: seg_o = 7'h79;
      4'd4: seg_o = 7'h33;
      4'd5: seg_o = 7'h5B;
      4'd6: seg_o = 7'h5F;
      4'd7: seg_o = 7'h70;
      4'd8: seg_o = 7'h7F;
      4'd9: seg_o = 7'h7B;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/bin_to_bcd_dd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
module bin_to_bcd_dd
  import score_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CW'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  // done_o marks the final iteration; bcd_o holds the result after that edge.
  assign done_o = (cnt_q == CW'(1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: accepts a binary score, converts to BCD, scans 4 digits.
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            seg_out,
  output state_e                dbg_state_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;

  state_e state_q, state_d;
  logic   accept, commit, conv_done;
  logic [BIN_W-1:0] sat_val;
  logic [BCD_W-1:0] conv_bcd, disp_q;

  // Handshake: a value transfers on any edge where value_valid && value_ready;
  // value_valid is ignored while value_ready is low.
  assign accept  = value_valid & value_ready;
  assign sat_val = (value_in > BCD_MAX) ? BCD_MAX : value_in;

  bin_to_bcd_dd u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (accept),
    .bin_i   (sat_val),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SHIFT;
      ST_SHIFT:  if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    value_ready = (state_q == ST_IDLE);
    commit      = (state_q == ST_COMMIT);
  end

  assign dbg_state_o = state_q;

  // Display register only changes at commit, so the old score stays up during conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    disp_q <= '0;
    else if (commit) disp_q <= conv_bcd;
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    lz;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          blank;
  logic [6:0]    seg_d, seg_q;
  logic [NUM_DIGITS-1:0] sel_d, sel_q;

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    idx_d   = (presc_q == PRESC_MAX) ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    lz[3] = (disp_q[15:12] == 4'd0);
    for (int i = 2; i >= 0; i--) lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'd0);
    cur_digit = disp_q[4*idx_q +: 4];
    blank     = (BLANK_LZ != 0) && (idx_q != 2'd0) && lz[idx_q];
    seg_d     = blank ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg);
    sel_d     = ~(NUM_DIGITS'(1) << idx_q);
  end

  bcd_to_seven_seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign seg_out   = seg_q;
  assign digit_sel = sel_q;

endmodule
